// File: rtl/instruction_fetch_unit.sv
// Instruction fetch stage: owns the program counter, drives the instruction
// memory word address, and pairs the returned word with its byte PC and a
// valid bit for decode. Handles stall, branch redirect and end-of-memory halt.
// The instruction memory registers its output, so a word read at one edge
// appears at instructionIn after that edge.

module instruction_fetch_unit #(
   parameter logic [63:0] RESET_PC  = 64'd0,
   parameter int unsigned MEM_WORDS = 1000
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        stall,
   input  logic        branchTaken,
   input  logic [63:0] branchTarget,
   output logic [63:0] readAddress,
   input  logic [31:0] instructionIn,
   output logic [31:0] instructionOut,
   output logic [63:0] pcOut,
   output logic        validOut,
   output logic        halted,
   output logic [31:0] fetchCount
);

   localparam int unsigned PC_W  = 64;
   localparam int unsigned CNT_W = 32;
   localparam logic [PC_W-1:0] PC_STEP   = PC_W'(4);
   localparam logic [PC_W-1:0] MEM_LIMIT = PC_W'(MEM_WORDS);

   // fetch-side PC (address presented to memory) and decode-side PC/valid
   logic [PC_W-1:0]  pc_f;
   logic [PC_W-1:0]  pc_d;
   logic             valid_d;
   logic [CNT_W-1:0] fetch_cnt;

   logic [PC_W-1:0]  pc_f_next;
   logic [PC_W-1:0]  pc_d_next;
   logic             valid_d_next;
   logic             count_en;
   logic [PC_W-1:0]  branch_pc;
   logic             fetch_halted;

   // low target bits are discarded: targets are always word aligned
   logic             unused_target_bits;

   // redirect target with the byte offset forced to zero
   assign branch_pc          = {branchTarget[63:2], 2'b00};
   assign unused_target_bits = ^branchTarget[1:0];

   // fetch stops once the fetch PC points past the end of instruction memory
   assign fetch_halted = (pc_f >> 2) >= MEM_LIMIT;

   // while stalled, re-read the decode-side word so the memory output holds
   assign readAddress = stall ? (pc_d >> 2) : (pc_f >> 2);

   // decode-side outputs come straight from state; the word passes through
   assign instructionOut = instructionIn;
   assign pcOut          = pc_d;
   assign validOut       = valid_d;
   assign halted         = fetch_halted;
   assign fetchCount     = fetch_cnt;

   // next-state selection: redirect, then stall, then halt, then sequential fetch
   always_comb begin
      pc_f_next    = pc_f;
      pc_d_next    = pc_d;
      valid_d_next = valid_d;
      count_en     = valid_d && !stall;

      if (branchTaken) begin
         pc_f_next    = branch_pc;
         valid_d_next = 1'b0;
      end else if (stall) begin
         pc_f_next    = pc_f;
         valid_d_next = valid_d;
      end else if (fetch_halted) begin
         valid_d_next = 1'b0;
      end else begin
         pc_d_next    = pc_f;
         valid_d_next = 1'b1;
         pc_f_next    = pc_f + PC_STEP;
      end
   end

   // PC / valid state with asynchronous reset
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         pc_f    <= RESET_PC;
         pc_d    <= '0;
         valid_d <= 1'b0;
      end else begin
         pc_f    <= pc_f_next;
         pc_d    <= pc_d_next;
         valid_d <= valid_d_next;
      end
   end

   // delivered-instruction counter, wraps modulo 2^32
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         fetch_cnt <= '0;
      end else if (count_en) begin
         fetch_cnt <= fetch_cnt + CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Randomized scoreboard bench for instruction_fetch_unit with a small
// registered instruction memory and a behavioural model of the fetch rules.

module tb_instruction_fetch_unit;

   localparam int unsigned MEM_WORDS = 24;
   localparam logic [63:0] RESET_PC  = 64'd0;

   logic        clock;
   logic        reset;
   logic        stall;
   logic        branchTaken;
   logic [63:0] branchTarget;
   logic [63:0] readAddress;
   logic [31:0] instructionIn;
   logic [31:0] instructionOut;
   logic [63:0] pcOut;
   logic        validOut;
   logic        halted;
   logic [31:0] fetchCount;

   instruction_fetch_unit #(
      .RESET_PC (RESET_PC),
      .MEM_WORDS(MEM_WORDS)
   ) dut (
      .clock         (clock),
      .reset         (reset),
      .stall         (stall),
      .branchTaken   (branchTaken),
      .branchTarget  (branchTarget),
      .readAddress   (readAddress),
      .instructionIn (instructionIn),
      .instructionOut(instructionOut),
      .pcOut         (pcOut),
      .validOut      (validOut),
      .halted        (halted),
      .fetchCount    (fetchCount)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // instruction memory with one cycle registered read
   logic [31:0] mem [MEM_WORDS];
   always @(posedge clock) begin
      if (readAddress < 64'(MEM_WORDS)) instructionIn <= mem[int'(readAddress[15:0])];
      else                              instructionIn <= 32'h0;
   end

   typedef struct packed {
      logic [63:0] raddr;
      logic [63:0] pc;
      logic        valid;
      logic        halt;
      logic [31:0] cnt;
   } exp_t;

   exp_t expq[$];
   int   n_cmp = 0;
   int   n_bad = 0;

   // reference model: the instruction stream as seen from decode
   logic [63:0] next_fetch;   // byte address of the next instruction to fetch
   logic [63:0] shown_pc;     // byte address of the instruction shown to decode
   bit          shown_valid;
   logic [31:0] delivered;

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
      n_cmp++;
      if (got !== want) begin
         n_bad++;
         $display("FAIL %s at %0t: got %h expected %h", name, $time, got, want);
      end
   endtask

   function automatic bit model_beyond_end();
      return (next_fetch / 4) >= 64'(MEM_WORDS);
   endfunction

   task automatic model_reset();
      next_fetch  = RESET_PC;
      shown_pc    = 64'd0;
      shown_valid = 1'b0;
      delivered   = 32'd0;
   endtask

   // apply one clock edge using the inputs that were held across it
   task automatic model_edge();
      if (reset) begin
         model_reset();
      end else begin
         if (shown_valid && !stall) delivered = delivered + 32'd1;
         if (branchTaken) begin
            next_fetch  = branchTarget & ~64'd3;
            shown_valid = 1'b0;
         end else if (stall) begin
            // everything holds
         end else if (model_beyond_end()) begin
            shown_valid = 1'b0;
         end else begin
            shown_pc    = next_fetch;
            shown_valid = 1'b1;
            next_fetch  = next_fetch + 64'd4;
         end
      end
   endtask

   function automatic exp_t model_view();
      exp_t e;
      e.raddr = stall ? (shown_pc / 4) : (next_fetch / 4);
      e.pc    = shown_pc;
      e.valid = shown_valid;
      e.halt  = model_beyond_end();
      e.cnt   = delivered;
      return e;
   endfunction

   // one cycle: model the edge, drive new inputs, queue the expected outputs
   task automatic step(input bit rst_v, input bit st, input bit br, input logic [63:0] tgt);
      exp_t e;
      @(posedge clock);
      #1;
      model_edge();
      stall        = st;
      branchTaken  = br;
      branchTarget = tgt;
      if (!rst_v) begin
         reset = 1'b0;
      end else if (!reset) begin
         // assert reset between edges; outputs must respond without a clock
         #2;
         reset = 1'b1;
         #1;
         model_reset();
         e = model_view();
         check("async readAddress", readAddress, e.raddr);
         check("async validOut", 64'(validOut), 64'(0));
         check("async fetchCount", 64'(fetchCount), 64'(0));
         check("async pcOut", pcOut, 64'd0);
         check("async halted", 64'(halted), 64'(0));
      end
      if (reset) model_reset();
      expq.push_back(model_view());
   endtask

   // monitor: compare DUT outputs against queued expectations mid-cycle
   initial begin
      exp_t e;
      forever begin
         @(negedge clock);
         if (expq.size() > 0) begin
            e = expq.pop_front();
            check("readAddress", readAddress, e.raddr);
            check("pcOut", pcOut, e.pc);
            check("validOut", 64'(validOut), 64'(e.valid));
            check("halted", 64'(halted), 64'(e.halt));
            check("fetchCount", 64'(fetchCount), 64'(e.cnt));
            if (e.valid) check("instructionOut", 64'(instructionOut), 64'(mem[int'(e.pc[15:2])]));
         end
      end
   end

   // stimulus: directed scenarios followed by randomized traffic
   initial begin
      int r;
      logic [63:0] tgt;
      for (int i = 0; i < int'(MEM_WORDS); i++) mem[i] = $urandom;
      mem[0] = 32'h8B1F03E5;
      mem[1] = 32'hF84000A4;
      mem[2] = 32'h8B040086;
      mem[3] = 32'hF80010A6;
      reset        = 1'b1;
      stall        = 1'b0;
      branchTaken  = 1'b0;
      branchTarget = 64'd0;
      model_reset();

      step(1, 0, 0, 64'd0);
      step(1, 0, 0, 64'd0);
      repeat (3) step(0, 0, 0, 64'd0);     // free run from reset
      repeat (3) step(0, 1, 0, 64'd0);     // stall holds decode word
      step(0, 0, 0, 64'd0);
      step(0, 0, 1, 64'h0D);               // redirect, low bits dropped
      repeat (3) step(0, 0, 0, 64'd0);
      step(0, 1, 1, 64'h40);               // redirect wins over stall
      step(0, 0, 1, 64'h08);               // back-to-back redirects
      repeat (2) step(0, 0, 0, 64'd0);
      step(0, 0, 1, 64'(4 * (MEM_WORDS - 3)));
      repeat (6) step(0, 0, 0, 64'd0);     // run into the end of memory
      step(0, 1, 0, 64'd0);                // stall while halted
      step(0, 0, 1, 64'd0);                // redirect clears halt
      repeat (6) step(0, 0, 0, 64'd0);
      step(0, 0, 1, 64'(4 * (MEM_WORDS + 5)));  // out-of-range target
      repeat (3) step(0, 0, 0, 64'd0);
      step(0, 0, 1, 64'd4);
      repeat (6) step(0, 0, 0, 64'd0);
      step(1, 0, 0, 64'd0);                // mid-run reset
      step(0, 0, 0, 64'd0);
      repeat (4) step(0, 0, 0, 64'd0);

      for (int c = 0; c < 2500; c++) begin
         r = int'($urandom_range(0, 99));
         if (r < 2) begin
            repeat (int'($urandom_range(1, 3))) step(1, $urandom_range(0, 1) == 0, 1'b0, 64'd0);
         end else begin
            if ($urandom_range(0, 1) == 0)
               tgt = 64'($urandom_range(0, MEM_WORDS - 1));
            else
               tgt = 64'($urandom_range(MEM_WORDS - 4, MEM_WORDS + 4));
            tgt = tgt * 64'd4 + 64'($urandom_range(0, 3));
            if ($urandom_range(0, 63) == 0) tgt = {32'hFFFF_FFFF, $urandom};
            step(0, $urandom_range(0, 3) == 0, $urandom_range(0, 7) == 0, tgt);
         end
      end
      step(0, 0, 0, 64'd0);

      @(negedge clock);
      #1;
      check("scoreboard drained", 64'(expq.size()), 64'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
